// File: rtl/req_arbiter8.sv
// rtl/req_arbiter8.sv - eight-requester arbiter, fixed priority or round robin, with hold timeout
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      level requests, req[i] held while agent i wants/uses the resource
//   rr_en    1 = round robin, 0 = fixed priority (req[7] highest); used only in IDLE
//   gnt      registered one-hot grant, zero when idle
//   gnt_id   registered encoded grant index, zero when idle
//   gnt_vld  registered, high exactly when gnt is non-zero
module req_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rr_en,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_vld
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Hold limit compared at 8 bits; preemption is disabled entirely when MAX_HOLD is 0.
    localparam logic [7:0] HOLD_LIM   = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
    localparam bit         PREEMPT_EN = (MAX_HOLD != 0);

    state_t     state;
    logic [2:0] rr_ptr;
    logic [7:0] hold_cnt;
    logic [7:0] mask;

    logic [7:0] cand;
    logic       win_found;
    logic [2:0] win_id;
    logic [2:0] rr_idx;
    logic       owner_req;
    logic       competitor;

    assign cand       = req & ~mask;
    assign owner_req  = req[gnt_id];
    assign competitor = |(req & ~gnt);

    // Both searches scan from lowest to highest precedence so the last hit is the winner.
    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
        rr_idx    = 3'd0;
        if (!rr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (cand[i]) begin
                    win_found = 1'b1;
                    win_id    = 3'(i);
                end
            end
        end else begin
            // Search order rr_ptr+1 .. rr_ptr+8; walk it backwards so rr_ptr+1 has the final say.
            for (int k = 8; k >= 1; k--) begin
                rr_idx = rr_ptr + 3'(k);
                if (cand[rr_idx]) begin
                    win_found = 1'b1;
                    win_id    = rr_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 8'h00;
            gnt_id   <= 3'd0;
            gnt_vld  <= 1'b0;
            rr_ptr   <= 3'd7;
            hold_cnt <= 8'd0;
            mask     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    mask <= 8'h00;
                    if (win_found) begin
                        state    <= GRANT;
                        gnt      <= 8'h01 << win_id;
                        gnt_id   <= win_id;
                        gnt_vld  <= 1'b1;
                        rr_ptr   <= win_id;
                        hold_cnt <= 8'd0;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        // Voluntary release wins over preemption and leaves no mask.
                        state   <= IDLE;
                        gnt     <= 8'h00;
                        gnt_id  <= 3'd0;
                        gnt_vld <= 1'b0;
                    end else if (PREEMPT_EN && hold_cnt == HOLD_LIM && competitor) begin
                        // Exclude the preempted owner from the next arbitration only.
                        state   <= IDLE;
                        mask    <= gnt;
                        gnt     <= 8'h00;
                        gnt_id  <= 3'd0;
                        gnt_vld <= 1'b0;
                    end else if (PREEMPT_EN && hold_cnt != HOLD_LIM) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_req_arbiter8.sv
// tb/tb_req_arbiter8.sv - self-checking bench for req_arbiter8
module tb_req_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rr_en;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;

    int n_cmp  = 0;
    int n_fail = 0;

    req_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rr_en   (rr_en),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       rr;
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
    } vec_t;

    vec_t tbl[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [7:0] g, input logic [2:0] id, input logic v);
        chk({name, ".gnt"}, 32'(gnt), 32'(g));
        chk({name, ".gnt_id"}, 32'(gnt_id), 32'(id));
        chk({name, ".gnt_vld"}, 32'(gnt_vld), 32'(v));
    endtask

    task automatic do_reset(input logic rr, input logic [7:0] rq);
        rst_n = 1'b0;
        rr_en = rr;
        req   = rq;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("reset_hold", 8'h00, 3'd0, 1'b0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        logic [2:0] exp_id;

        rst_n = 1'b0;
        req   = 8'h00;
        rr_en = 1'b0;

        tbl[0]  = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1};
        tbl[1]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[2]  = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1};
        tbl[3]  = '{8'h01, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[4]  = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1};
        tbl[5]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[6]  = '{8'h3C, 1'b0, 8'h20, 3'd5, 1'b1};
        tbl[7]  = '{8'h3C, 1'b0, 8'h20, 3'd5, 1'b1};
        tbl[8]  = '{8'h1C, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[9]  = '{8'h1C, 1'b0, 8'h10, 3'd4, 1'b1};
        tbl[10] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[11] = '{8'h09, 1'b1, 8'h01, 3'd0, 1'b1};
        tbl[12] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[13] = '{8'h09, 1'b1, 8'h08, 3'd3, 1'b1};
        tbl[14] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};

        // Reset with all requests high, RR mode then fixed mode
        do_reset(1'b1, 8'hFF);
        tick();
        chk_out("reset_rr_first", 8'h01, 3'd0, 1'b1);
        do_reset(1'b0, 8'hFF);
        tick();
        chk_out("reset_fixed_first", 8'h80, 3'd7, 1'b1);

        // Table-driven vectors from a clean reset
        do_reset(1'b0, 8'h00);
        tick();
        for (int i = 0; i < 15; i++) begin
            req   = tbl[i].req;
            rr_en = tbl[i].rr;
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].id, tbl[i].v);
        end

        // Round robin rotation 0..7,0 with one idle cycle between grants
        do_reset(1'b1, 8'hFF);
        tick();
        for (int i = 0; i < 9; i++) begin
            exp_id = 3'(i % 8);
            chk_out($sformatf("rr_grant%0d", i), 8'h01 << exp_id, exp_id, 1'b1);
            tick();
            chk($sformatf("rr_hold%0d", i), 32'(gnt_vld), 32'd1);
            req = 8'hFF & ~(8'h01 << exp_id);
            tick();
            chk($sformatf("rr_gap%0d", i), 32'(gnt_vld), 32'd0);
            req = 8'hFF;
            tick();
        end

        // Preemption after MAX_HOLD cycles, fixed mode then RR mode
        for (int m = 0; m < 2; m++) begin
            req   = 8'h00;
            rr_en = 1'(m);
            tick();
            tick();
            req = 8'h04;
            tick();
            chk_out($sformatf("pre%0d_first", m), 8'h04, 3'd2, 1'b1);
            req = 8'h24;
            cnt = 0;
            while (gnt == 8'h04 && cnt < 12) begin
                cnt++;
                tick();
            end
            chk($sformatf("pre%0d_hold_cycles", m), 32'(cnt), 32'd4);
            chk($sformatf("pre%0d_gap", m), 32'(gnt_vld), 32'd0);
            tick();
            chk_out($sformatf("pre%0d_next", m), 8'h20, 3'd5, 1'b1);
        end

        // Competitor arriving after hold_cnt saturation drops the grant at the next edge
        req   = 8'h00;
        rr_en = 1'b0;
        tick();
        tick();
        req = 8'h04;
        tick();
        for (int i = 0; i < 6; i++) tick();
        chk_out("sat_still_owned", 8'h04, 3'd2, 1'b1);
        req = 8'h24;
        tick();
        chk("sat_drop", 32'(gnt_vld), 32'd0);
        tick();
        chk_out("sat_next", 8'h20, 3'd5, 1'b1);

        // Asynchronous reset mid-GRANT with owner 5; rr_ptr must return to 7
        req = 8'h00;
        tick();
        tick();
        req = 8'h20;
        tick();
        chk_out("async_pre", 8'h20, 3'd5, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_drop", 8'h00, 3'd0, 1'b0);
        #1;
        rst_n = 1'b1;
        rr_en = 1'b1;
        req   = 8'hFF;
        tick();
        chk_out("async_rrptr", 8'h01, 3'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
